// File: rtl/hazard_ctl.sv
// Hazard/forwarding controller for the rv32 5-stage pipeline: tracks a shadow
// EX/MEM/WB copy of register usage, detects load-use and branch flushes, drives forwarding.
module hazard_ctl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_id,
  input  logic             id_valid,
  input  logic             pc_sel,
  output logic             stall_pc,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [31:0]      bubble_instr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
    logic       used1;
    logic       used2;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } shadow_t;

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

  state_t     state_q, state_d;
  shadow_t    ex_q, mem_q, wb_q, dec;
  logic       load_use, stall;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_comb begin
    dec = '0;
    if (id_valid) begin
      dec.rd  = instr_id[11:7];
      dec.rs1 = instr_id[19:15];
      dec.rs2 = instr_id[24:20];
      case (instr_id[6:0])
        7'b0110011: begin dec.used1 = 1'b1; dec.used2 = 1'b1; dec.wen = 1'b1; end
        7'b0010011: begin dec.used1 = 1'b1; dec.wen = 1'b1; end
        7'b0000011: begin dec.used1 = 1'b1; dec.wen = 1'b1; dec.is_load = 1'b1; end
        7'b1100111: begin dec.used1 = 1'b1; dec.wen = 1'b1; end
        7'b0100011,
        7'b1100011: begin dec.used1 = 1'b1; dec.used2 = 1'b1; end
        7'b1101111,
        7'b0110111,
        7'b0010111: dec.wen = 1'b1;
        default: ;
      endcase
      // x0 is never a real destination, so it must never match for hazards/forwarding
      if (dec.rd == 5'd0) dec.wen = 1'b0;
    end
  end

  assign load_use = ex_q.is_load && ex_q.wen &&
                    ((dec.used1 && dec.rs1 == ex_q.rd) || (dec.used2 && dec.rs2 == ex_q.rd));

  // Controls are gated by reset so everything reads 0 while it is held.
  always_comb begin
    state_d  = RUN;
    stall    = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (rst) begin
      if (pc_sel) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        state_d  = FLUSH;
      end else if (load_use && state_q != LDSTALL) begin
        stall   = 1'b1;
        state_d = LDSTALL;
      end
    end
  end

  assign stall_pc = stall;
  assign stall_id = stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= (stall || flush_ex) ? '0 : dec;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
      flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_ex};
    end
  end

  // MEM outranks WB: it holds the younger write to the same register.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (ex_q.used1) begin
      if (mem_q.wen && mem_q.rd == ex_q.rs1)     fwd_a_sel = 2'b01;
      else if (wb_q.wen && wb_q.rd == ex_q.rs1)  fwd_a_sel = 2'b10;
    end
    if (ex_q.used2) begin
      if (mem_q.wen && mem_q.rd == ex_q.rs2)     fwd_b_sel = 2'b01;
      else if (wb_q.wen && wb_q.rd == ex_q.rs2)  fwd_b_sel = 2'b10;
    end
  end

  assign bubble_instr = NOP_INSTR;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

  logic unused_ok;
  assign unused_ok = ^{instr_id[31:25], instr_id[14:12], mem_q.is_load, mem_q.used1, mem_q.used2,
                       mem_q.rs1, mem_q.rs2, wb_q.is_load, wb_q.used1, wb_q.used2, wb_q.rs1, wb_q.rs2};

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl; a second instance with 4-bit counters covers wrap-around.
module tb_hazard_ctl;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD5    = 32'h0020_82B3; // add x5,x1,x2
  localparam logic [31:0] SUB6    = 32'h4032_8333; // sub x6,x5,x3
  localparam logic [31:0] LW5     = 32'h0000_A283; // lw  x5,0(x1)
  localparam logic [31:0] ADD6_57 = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] LW0     = 32'h0000_A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD6_00 = 32'h0000_0333; // add x6,x0,x0

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_id = '0;
  logic        id_valid = 1'b0;
  logic        pc_sel = 1'b0;
  logic        stall_pc, stall_id, flush_id, flush_ex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] bubble_instr, stall_cnt, flush_cnt;
  logic        stall_pc4, stall_id4, flush_id4, flush_ex4;
  logic [1:0]  fwd_a_sel4, fwd_b_sel4;
  logic [31:0] bubble_instr4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctl dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .pc_sel(pc_sel),
    .stall_pc(stall_pc), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .bubble_instr(bubble_instr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid), .pc_sel(pc_sel),
    .stall_pc(stall_pc4), .stall_id(stall_id4), .flush_id(flush_id4), .flush_ex(flush_ex4),
    .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4), .bubble_instr(bubble_instr4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // A load in MEM matching an EX operand means the load-use stall was missed.
  always @(negedge clk) begin
    if (rst && dut.mem_q.is_load && dut.mem_q.wen &&
        ((dut.ex_q.used1 && dut.ex_q.rs1 == dut.mem_q.rd) ||
         (dut.ex_q.used2 && dut.ex_q.rs2 == dut.mem_q.rd))) begin
      errors++;
      $display("FAIL mem_load_fwd: load in MEM feeds EX rd=%0d", dut.mem_q.rd);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic ps);
    instr_id = ins; id_valid = v; pc_sel = ps; #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive('0, 1'b0, 1'b0);
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(LW5, 1'b1, 1'b1);
    checks++;
    if ({stall_pc, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel} !== 8'h00) begin
      errors++; $display("FAIL rst_ctrl: got %b want 00000000", {stall_pc, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel});
    end
    checks++;
    if (bubble_instr !== NOP || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_vals: bubble=%h sc=%0d fc=%0d want %h 0 0", bubble_instr, stall_cnt, flush_cnt, NOP);
    end
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive('0, 1'b0, 1'b0);
      checks++;
      if ({stall_pc, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel} !== 8'h00 ||
          stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
        errors++; $display("FAIL idle_%0d: ctrl=%b sc=%0d fc=%0d want 0", i,
                           {stall_pc, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel}, stall_cnt, flush_cnt);
      end
      cyc();
    end
  endtask

  task automatic test_fwd_mem();
    do_reset();
    drive(ADD5, 1'b1, 1'b0); cyc();
    drive(SUB6, 1'b1, 1'b0); cyc();
    drive('0, 1'b0, 1'b0);
    checks++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00 || stall_pc !== 1'b0) begin
      errors++; $display("FAIL fwd_mem: a=%b b=%b stall=%b want 01 00 0", fwd_a_sel, fwd_b_sel, stall_pc);
    end
    cyc();
  endtask

  task automatic test_fwd_wb();
    do_reset();
    drive(ADD5, 1'b1, 1'b0); cyc();
    drive(NOP, 1'b1, 1'b0); cyc();
    drive(SUB6, 1'b1, 1'b0); cyc();
    drive('0, 1'b0, 1'b0);
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL fwd_wb: a=%b b=%b want 10 00", fwd_a_sel, fwd_b_sel);
    end
    cyc();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(LW5, 1'b1, 1'b0); cyc();
    drive(ADD6_57, 1'b1, 1'b0);
    checks++;
    if ({stall_pc, stall_id, flush_id, flush_ex} !== 4'b1100) begin
      errors++; $display("FAIL lu_stall: got %b want 1100", {stall_pc, stall_id, flush_id, flush_ex});
    end
    cyc();
    drive(ADD6_57, 1'b1, 1'b0);
    checks++;
    if ({stall_pc, stall_id, fwd_a_sel, fwd_b_sel} !== 6'b000000 || stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_bubble: ctrl=%b sc=%0d want 000000 1", {stall_pc, stall_id, fwd_a_sel, fwd_b_sel}, stall_cnt);
    end
    cyc();
    drive('0, 1'b0, 1'b0);
    checks++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00 || stall_pc !== 1'b0 || stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_fwd: a=%b b=%b stall=%b sc=%0d want 10 00 0 1", fwd_a_sel, fwd_b_sel, stall_pc, stall_cnt);
    end
    cyc();
  endtask

  task automatic test_load_x0();
    do_reset();
    drive(LW0, 1'b1, 1'b0); cyc();
    drive(ADD6_00, 1'b1, 1'b0);
    checks++;
    if (stall_pc !== 1'b0 || stall_id !== 1'b0) begin
      errors++; $display("FAIL x0_stall: stall_pc=%b stall_id=%b want 0 0", stall_pc, stall_id);
    end
    cyc();
    drive('0, 1'b0, 1'b0);
    checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL x0_fwd: a=%b b=%b sc=%0d want 00 00 0", fwd_a_sel, fwd_b_sel, stall_cnt);
    end
    cyc();
  endtask

  task automatic test_flush_priority();
    do_reset();
    drive(LW5, 1'b1, 1'b0); cyc();
    drive(ADD6_57, 1'b1, 1'b1);
    checks++;
    if ({stall_pc, stall_id, flush_id, flush_ex} !== 4'b0011) begin
      errors++; $display("FAIL fl_prio: got %b want 0011", {stall_pc, stall_id, flush_id, flush_ex});
    end
    cyc();
    drive('0, 1'b0, 1'b0);
    checks++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0 || flush_ex !== 1'b0) begin
      errors++; $display("FAIL fl_cnt: fc=%0d sc=%0d fx=%b want 1 0 0", flush_cnt, stall_cnt, flush_ex);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive('0, 1'b0, 1'b1); cyc();
    drive('0, 1'b0, 1'b1);
    checks++;
    if ({flush_id, flush_ex} !== 2'b11) begin
      errors++; $display("FAIL b2b_flush: got %b want 11", {flush_id, flush_ex});
    end
    cyc();
    drive('0, 1'b0, 1'b0);
    checks++;
    if (flush_cnt !== 32'd2 || flush_ex !== 1'b0) begin
      errors++; $display("FAIL b2b_cnt: fc=%0d fx=%b want 2 0", flush_cnt, flush_ex);
    end
    cyc();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(LW5, 1'b1, 1'b0); cyc();
    drive(ADD6_57, 1'b1, 1'b0); cyc();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({stall_pc, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel} !== 8'h00 ||
        stall_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin
      errors++; $display("FAIL rst_async: ctrl=%b sc=%0d sc4=%0d want 0", {stall_pc, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel}, stall_cnt, stall_cnt4);
    end
    cyc();
    rst = 1'b1;
    drive(LW5, 1'b1, 1'b0); cyc();
    drive(ADD6_57, 1'b1, 1'b0);
    checks++;
    if (stall_pc !== 1'b1 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_resume: stall=%b sc=%0d want 1 0", stall_pc, stall_cnt);
    end
    cyc();
    drive('0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++; $display("FAIL rst_resume_cnt: sc=%0d want 1", stall_cnt);
    end
    cyc();
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(LW5, 1'b1, 1'b0); cyc();
      drive(ADD6_57, 1'b1, 1'b0); cyc();
      drive(ADD6_57, 1'b1, 1'b0); cyc();
    end
    drive('0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt4 !== 4'd1 || stall_cnt !== 32'd17) begin
      errors++; $display("FAIL cnt_wrap: sc4=%0d sc=%0d want 1 17", stall_cnt4, stall_cnt);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_load_x0();
    test_flush_priority();
    test_back_to_back();
    test_reset_mid_stall();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Hazard and forwarding controller for the rv32 5-stage pipeline. It works in the opposite direction to the stage control chain: it consumes the instruction stream and resolved branch decisions, and drives stall, flush and forwarding controls back upstream.
- It keeps its own shadow pipeline (EX/MEM/WB) of rd, register-write and load flags. The shadow pipeline stays in lock-step with the datapath stage registers.
- It also counts stall and flush cycles for performance reporting.

Parameters:
- NOP_INSTR, 32'h00000013, encoding reported in bubble_instr when a bubble is injected (addi x0,x0,0).
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low
- instr_id  in  32  instruction currently held in the decode stage
- id_valid  in  1  instr_id is a real instruction (0 = bubble)
- pc_sel  in  1  branch/jump taken, resolved in EX this cycle
- stall_pc  out  1  hold the PC this cycle
- stall_id  out  1  hold the IF/ID register this cycle
- flush_id  out  1  replace the IF/ID contents with a bubble at the next edge
- flush_ex  out  1  replace the ID/EX contents with a bubble at the next edge
- fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB result
- fwd_b_sel  out  2  same encoding, operand B
- bubble_instr  out  32  NOP_INSTR; driven into ID/EX when stalling or flushing
- stall_cnt  out  CNT_W  cycles in which stall_pc was asserted
- flush_cnt  out  CNT_W  cycles in which flush_ex was asserted

Behaviour:
- Decode of instr_id, opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20]:
  - uses rs1: R 0110011, I-alu 0010011, load 0000011, JALR 1100111, S 0100011, B 1100011.
  - uses rs2: R, S, B.
  - writes rd: R, I-alu, load, JAL 1101111, JALR, LUI 0110111, AUIPC 0010111.
  - is_load: opcode 0000011.
  - Unknown opcodes use no registers and write nothing.
  - id_valid=0 clears all flags.
- Shadow registers per stage (EX, MEM, WB), each holding {rd[4:0], wen, is_load, used1, used2, rs1, rs2}.
  - A writer with rd=0 is stored with wen=0.
- Load-use hazard (combinational): EX.is_load AND EX.wen, AND (used1 with rs1==EX.rd, OR used2 with rs2==EX.rd).
- FSM states: RUN, LDSTALL, FLUSH. Registered state; outputs are combinational from the state and the current inputs.
  - RUN, pc_sel=1 -> FLUSH. Assert flush_id=flush_ex=1 this cycle. No stall, even if load-use is also true (the ID instruction is wrong-path).
  - RUN, load-use=1, pc_sel=0 -> LDSTALL. Assert stall_pc=stall_id=1 and flush_ex=0. EX shadow loads a bubble at the edge.
  - LDSTALL lasts exactly one cycle, then returns to RUN. The load is then in MEM and the dependent instruction enters EX when the load reaches WB, so forwarding comes from WB.
  - FLUSH lasts one cycle. The fetched-after-branch instruction is already a bubble. Returns to RUN; a new pc_sel in FLUSH is handled as in RUN.
- Shadow pipeline update at each rising edge:
  - MEM <= EX and WB <= MEM, always.
  - EX <= bubble if a stall or flush_ex is active; otherwise EX <= decode(instr_id).
- Forwarding (combinational, from the EX shadow against MEM/WB):
  - fwd_a_sel=01 if MEM.wen and MEM.rd==EX.rs1 and EX.used1.
  - Otherwise fwd_a_sel=10 if WB.wen and WB.rd==EX.rs1 and EX.used1.
  - Otherwise 00.
  - MEM has priority over WB. The same rules apply to fwd_b_sel using rs2/used2.
  - MEM.is_load with a match to EX never occurs: the load-use stall prevents it. Verification shall assert this.
- Counters:
  - stall_cnt increments on cycles with stall_pc=1; flush_cnt increments on cycles with flush_ex=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Reset (rst=0, asynchronous):
  - State goes to RUN; all shadow stages clear to bubble; counters go to 0.
  - All outputs are 0 except bubble_instr=NOP_INSTR.
  - Reset may assert mid-stall or mid-flush; operation resumes in RUN on the first edge after release.

Test Plan:
- Reset, then release with id_valid=0 for 5 cycles -> all controls 0, fwd 00, counters 0.
- add x5,x1,x2 (0x002082B3) followed by sub x6,x5,x3 -> when sub is in EX, fwd_a_sel=01. Insert one NOP between them -> fwd_a_sel=10.
- lw x5,0(x1) (0x0000A283) followed by add x6,x5,x7 -> one cycle with stall_pc=stall_id=1, EX shadow becomes a bubble, then fwd_a_sel=10. stall_cnt=1.
- Load to x0 followed by a user of x0 -> no stall, fwd 00.
- pc_sel=1 in the same cycle as a load-use condition -> flush_id=flush_ex=1, stall_pc=0. flush_cnt=1, stall_cnt unchanged.
- rst pulled low during LDSTALL -> outputs clear immediately (asynchronously). After release, state is RUN and counters are 0.
- Drive CNT_W=4 with 17 consecutive load-use stalls -> stall_cnt wraps to 1.
